gcd_engine: RTL and testbench

GCD_ENGINE -- requirements
Module: gcd_engine

---
 rtl/gcd_engine.sv | 120 ++++++++++++
 tb/tb_gcd_engine.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/gcd_engine.sv
// Iterative GCD engine: IDLE -> CALC (one reduction step per cycle) -> DONE pulse.
// Define GCD_STEIN_EN to use the binary (Stein) reduction step instead of plain subtraction.
module gcd_engine #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] gcd_out,
    output logic [WIDTH-1:0] iter_cnt
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] a_nxt, b_nxt;
    logic [WIDTH-1:0] result;
    logic             terminate;

    assign terminate = (a_q == b_q) || (a_q == '0) || (b_q == '0);

`ifdef GCD_STEIN_EN
    localparam int KW = $clog2(WIDTH) + 1;
    logic [KW-1:0] k_q, k_nxt;

    // Binary step: strip common factors of two into k, odd/odd pairs subtract.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        a_nxt = a_q;
        b_nxt = b_q;
        k_nxt = k_q;
        case ({a_q[0], b_q[0]})
            2'b00: begin
                a_nxt = a_q >> 1;
                b_nxt = b_q >> 1;
                k_nxt = k_q + 1'b1;
            end
            2'b01:   a_nxt = a_q >> 1;
            2'b10:   b_nxt = b_q >> 1;
            default: begin
                if (a_q > b_q) a_nxt = a_q - b_q;
                else           b_nxt = b_q - a_q;
            end
        endcase
    end

    assign result = (a_q | b_q) << k_q;
`else
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        a_nxt = a_q;
        b_nxt = b_q;
        if (a_q > b_q) a_nxt = a_q - b_q;
        else           b_nxt = b_q - a_q;
    end

    assign result = a_q | b_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (terminate) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            gcd_out  <= '0;
            iter_cnt <= '0;
`ifdef GCD_STEIN_EN
            k_q      <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    a_q      <= a_in;
                    b_q      <= b_in;
                    iter_cnt <= '0;
`ifdef GCD_STEIN_EN
                    k_q      <= '0;
`endif
                end
                CALC: if (terminate) begin
                    gcd_out <= result;
                end else begin
                    a_q <= a_nxt;
                    b_q <= b_nxt;
`ifdef GCD_STEIN_EN
                    k_q <= k_nxt;
`endif
                    // Counter saturates; the reduction itself keeps going.
                    if (iter_cnt != '1) iter_cnt <= iter_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_engine.sv
// Scoreboard bench for gcd_engine: stimulus pushes expected result, iteration
// count and done-edge index; a monitor pops and compares on every done pulse.
module tb_gcd_engine;

    localparam int WIDTH = 16;

    typedef struct {
        logic [WIDTH-1:0] gcd;
        logic [WIDTH-1:0] iters;
        int               done_edge;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a_in = '0;
    logic [WIDTH-1:0] b_in = '0;
    logic             busy, done;
    logic [WIDTH-1:0] gcd_out, iter_cnt;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   edges = 0;

    gcd_engine #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .gcd_out  (gcd_out),
        .iter_cnt (iter_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges++;

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("gcd_out", gcd_out, e.gcd);
                check("iter_cnt", iter_cnt, e.iters);
                check("done_edge", edges, e.done_edge);
                check("busy_with_done", busy, 1);
            end
        end
    end

    // Drive a start pulse; the next rising edge is the start edge.
    task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, output int start_edge);
        @(negedge clk);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        start_edge = edges + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Done is seen in the (steps+2)-th cycle counting the start edge as the first.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] g, input logic [WIDTH-1:0] steps);
        int   se;
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        se    = edges + 1;
        e.gcd = g;
        e.iters = steps;
        e.done_edge = se + int'(steps) + 1;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int budget = 70000;
        while (!done && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            check("done_timeout", 0, 1);
        end else begin
            @(negedge clk);
            check("done_one_cycle", done, 0);
            check("busy_after_done", busy, 0);
        end
    endtask

    initial begin
        int dummy;
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_gcd", gcd_out, 0);
        check("reset_iter", iter_cnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

`ifdef GCD_STEIN_EN
        issue(16'd100, 16'd125, 16'd25, 16'd5);  wait_done();
        issue(16'd12,  16'd18,  16'd6,  16'd4);  wait_done();
`else
        issue(16'd100, 16'd125, 16'd25, 16'd4);  wait_done();
        issue(16'd12,  16'd18,  16'd6,  16'd2);  wait_done();
`endif
        check("hold_gcd", gcd_out, 6);
        issue(16'd0, 16'd37, 16'd37, 16'd0);     wait_done();
        issue(16'd0, 16'd0,  16'd0,  16'd0);     wait_done();

        // Long run with a stray start mid-operation that must be ignored.
`ifdef GCD_STEIN_EN
        issue(16'd1, 16'd65535, 16'd1, 16'd30);
`else
        issue(16'd1, 16'd65535, 16'd1, 16'd65534);
`endif
        repeat (5) @(negedge clk);
        start = 1'b1;
        a_in  = 16'd6;
        b_in  = 16'd4;
        @(negedge clk);
        start = 1'b0;
        check("busy_mid_op", busy, 1);
        wait_done();

        // Abort during CALC: no done may follow and everything clears at once.
        drive(16'd100, 16'd125, dummy);
        @(negedge clk);
        check("busy_before_abort", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_gcd", gcd_out, 0);
        check("abort_iter", iter_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_after_abort", busy, 0);

`ifdef GCD_STEIN_EN
        issue(16'd48, 16'd36, 16'd12, 16'd6);    wait_done();
`else
        issue(16'd48, 16'd36, 16'd12, 16'd3);    wait_done();
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
